apb_rr_scheduler: RTL
=====================

Name: apb_rr_scheduler

Overview:
- Shares one APB transfer sequencer between N_REQ requesters using round-robin arbitration.
- Latches the winning requester's command (address, write data, direction) and drives the sequencer's req/done handshake.
- Returns read data and a one-cycle ack to the winning requester.
- Sits between the bus-master clients (CPU bridge, DMA, debug) and the APB sequencer that generates p_sel/p_enable.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  N_REQ  per-requester request; held high until the matching ack_o bit pulses.
- write_i  in  N_REQ  per-requester direction; 1 = write.
- addr_i  in  N_REQ*ADDR_W  flattened addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
- wdata_i  in  N_REQ*DATA_W  flattened write data, same packing as addr_i.
- ack_o  out  N_REQ  one-hot, one-cycle completion pulse.
- rdata_o  out  DATA_W  read data; valid while any ack_o bit is high.
- grant_id_o  out  $clog2(N_REQ)  index of the current or last granted requester.
- busy_o  out  1  high in S_BUSY and S_RESP.
- ctrl_req  out  1  request to the APB sequencer.
- ctrl_write  out  1  latched direction.
- ctrl_addr  out  ADDR_W  latched address.
- ctrl_wdata  out  DATA_W  latched write data.
- ctrl_done  in  1  sequencer completion; high for one cycle in the access phase when p_ready is high.
- ctrl_rdata  in  DATA_W  prdata; valid when ctrl_done is high.

Behaviour:
- Reset (async, active-high):
  - state = S_IDLE.
  - ack_o = 0, rdata_o = 0, ctrl_addr/ctrl_wdata/ctrl_write = 0, grant_id_o = 0.
  - Internal last-grant pointer = N_REQ-1, so requester 0 has highest priority after reset.
- States: S_IDLE, S_BUSY, S_RESP.
- S_IDLE, when |req_i:
  - Winner is the first asserted req_i bit, searching from (last+1) mod N_REQ upward with wrap-around.
  - On the clock edge: register the winner's addr/wdata/write into ctrl_*, set grant_id_o and last to the winner, go to S_BUSY.
  - If no req_i bit is set, stay in S_IDLE.
- S_BUSY:
  - ctrl_req = ~ctrl_done. It is low in the done cycle, so the sequencer returns to idle and never starts an unrequested back-to-back transfer.
  - ctrl_* are stable for the whole state.
  - On ctrl_done: capture ctrl_rdata into rdata_o (writes also capture it; the value is don't-care) and go to S_RESP.
  - Unbounded p_ready wait states are legal; there is no timeout.
- S_RESP (one cycle):
  - ack_o[grant_id_o] = 1; all other ack bits are 0.
  - Next state is S_IDLE unconditionally.
- Latency: req_i rise in S_IDLE -> ctrl_req high next cycle -> sequencer address phase -> access phase. With zero wait states, ack_o pulses 4 cycles after req_i rises.
- Requesters drop req_i in the cycle after ack_o. The S_IDLE cycle that follows prevents a double grant.
- ack_o and ctrl_req are never both high.
- Requests arriving in S_BUSY or S_RESP wait; there is no preemption.
- A requester that drops req_i before its ack is a protocol violation. Once granted, the transfer completes anyway.
- Inputs of non-granted requesters are ignored after the grant edge, and changes to them have no effect.
- With all requesters asserted continuously, the grant order is 0,1,2,…,N_REQ-1,0,…
- Reset mid-transfer returns to S_IDLE immediately with no ack. The sequencer is reset on the same domain reset.

Decomposition:
- Package apb_sched_pkg holds the state typedef (S_IDLE, S_BUSY, S_RESP as a 2-bit enum) and the localparam helper for the index width.
- Sub-module rr_arbiter, parameterised on N_REQ:
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant, binary index, any_req.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single write: req_i=0001, write_i[0]=1, addr=0x40, wdata=0xDEAD_BEEF, p_ready tied high -> ctrl_addr=0x40, ctrl_write=1, ack_o=0001 exactly once, 4 cycles after req.
- Read with 3 wait states: requester 2 reads 0x1C, sequencer returns 0x1234_5678 -> ctrl_req held through the wait states, rdata_o=0x1234_5678 with ack_o=0100, ack_o pulses 7 cycles after req.
- Fairness: req_i=1111 held high with each ack honoured, all addresses distinct -> grant_id_o sequence 0,1,2,3,0,1; no requester granted twice in 4 grants.
- Contention after grant: requester 1 granted, requester 3 rises mid-S_BUSY and requester 1 changes its addr -> ctrl_addr unchanged, requester 3 granted in the S_IDLE cycle after the ack.
- Reset mid-S_BUSY: assert reset during the access phase -> ack_o stays 0, ctrl_req=0, state S_IDLE; after release, req_i=1000 gives grant_id_o=3 and req_i=1001 gives grant 0.
- Done-cycle check: on every ctrl_done, ctrl_req=0 in the same cycle, and the sequencer shows p_sel=0 in the following cycle.

Source files
------------

// File: rtl/apb_sched_pkg.sv
// Shared types for the APB round-robin scheduler.
//   state_e : scheduler FSM states (2-bit encoding)
//   idx_w() : width of a requester index, never less than one bit
package apb_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   last    : index of the previous winner; search starts one above it
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : binary index of the winner (zero when no request)
//   any_req : at least one request is asserted
module rr_arbiter
    import apb_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);
    // One spare bit so start + offset (at most 2*N_REQ-2) cannot overflow.
    localparam int CW = IDX_W + 1;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [CW-1:0]    start;
    logic [CW-1:0]    sum;
    logic [N_REQ-1:0] rot;
    logic             found;

    always_comb begin
        start   = CW'(last) + CW'(1);
        if (start == CW'(N_REQ)) start = '0;
        // Rotate so bit 0 is the highest-priority requester this round.
        rot     = N_REQ'({req, req} >> start);
        found   = 1'b0;
        sum     = '0;
        gnt_idx = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                sum   = start + CW'(j);
                if (sum >= CW'(N_REQ)) sum = sum - CW'(N_REQ);
                gnt_idx = IDX_W'(sum);
            end
        end
        any_req = |req;
        gnt     = any_req ? (ONE << gnt_idx) : '0;
    end

endmodule

// File: rtl/apb_rr_scheduler.sv
// Round-robin front end sharing one APB transfer sequencer between N_REQ
// bus masters. The winner's command is latched into ctrl_*, the sequencer
// is driven through ctrl_req/ctrl_done, and read data plus a one-cycle
// ack are returned to the winner.
//   req_i/write_i/addr_i/wdata_i : per-requester commands (flattened buses)
//   ack_o, rdata_o               : completion pulse and read data
//   grant_id_o, busy_o           : current/last winner, transfer in flight
//   ctrl_*                       : sequencer handshake and latched command
module apb_rr_scheduler
    import apb_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         write_i,
    input  logic [N_REQ*ADDR_W-1:0]  addr_i,
    input  logic [N_REQ*DATA_W-1:0]  wdata_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     busy_o,
    output logic                     ctrl_req,
    output logic                     ctrl_write,
    output logic [ADDR_W-1:0]        ctrl_addr,
    output logic [DATA_W-1:0]        ctrl_wdata,
    input  logic                     ctrl_done,
    input  logic [DATA_W-1:0]        ctrl_rdata
);
    localparam int IDX_W = idx_w(N_REQ);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    gid_q, gid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [N_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (req_i),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    // One-hot select of the winner's command.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_gnt[k]) begin
                sel_addr  = addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[k*DATA_W +: DATA_W];
            end
        end
        sel_write = |(write_i & arb_gnt);
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    write_d = sel_write;
                    gid_d   = arb_idx;
                    last_d  = arb_idx;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ctrl_done) begin
                    rdata_d = ctrl_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= LAST_RST;
            gid_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    // ctrl_req drops in the done cycle so the sequencer goes idle instead
    // of launching an unrequested back-to-back transfer.
    always_comb begin
        ctrl_req   = (state_q == S_BUSY) && !ctrl_done;
        ack_o      = (state_q == S_RESP) ? (ONE << gid_q) : '0;
        busy_o     = (state_q != S_IDLE);
        grant_id_o = gid_q;
        rdata_o    = rdata_q;
        ctrl_addr  = addr_q;
        ctrl_wdata = wdata_q;
        ctrl_write = write_q;
    end

endmodule
